// File: rtl/sif_xa_wa_fifo_bridge.sv
// Buffered XA->WA bridge: XA writes fill a DEPTH-deep FIFO and reads peek its head. WA drains it over valid/ready.
// A push is visible on wa_data the cycle after the edge; peek, read-valid and error pulses are registered. The head is held stable while wa_rdy is low.
module sif_xa_wa_fifo_bridge #(
    parameter int DATA_W   = 16,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = 6
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       xa_wr_s,
    input  logic                       xa_rd_s,
    input  logic [DATA_W-1:0]          xa_data_in,
    output logic [DATA_W-1:0]          xa_data_out,
    output logic                       xa_rd_vld,
    output logic [1:0]                 xa_err,
    output logic                       xa_af,
    output logic [DATA_W-1:0]          wa_data,
    output logic                       wa_vld,
    input  logic                       wa_rdy,
    output logic [$clog2(DEPTH+1)-1:0] fifo_cnt
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_ILL   = 2'b01;
    localparam logic [1:0] ERR_OVER  = 2'b10;
    localparam logic [1:0] ERR_UNDER = 2'b11;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] rd_dat_q, rd_dat_d;
    logic              rd_vld_q, rd_vld_d;
    logic [1:0]        err_q, err_d;

    logic op_wr, op_rd, op_ill, empty, full, push, pop;

    always_comb begin
        op_wr  = xa_wr_s & ~xa_rd_s;
        op_rd  = xa_rd_s & ~xa_wr_s;
        op_ill = xa_wr_s & xa_rd_s;
        empty  = (cnt_q == '0);
        full   = (cnt_q == CW'(DEPTH));
        // Full is judged before this cycle's pop, so a write at full is dropped even when WA drains.
        push   = op_wr & ~full;
        pop    = ~empty & wa_rdy;

        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        cnt_d    = cnt_q + CW'(push) - CW'(pop);

        rd_vld_d = op_rd & ~empty;
        rd_dat_d = rd_vld_d ? mem_q[rd_ptr_q] : rd_dat_q;

        err_d = ERR_NONE;
        if (op_ill)              err_d = ERR_ILL;
        else if (op_wr && full)  err_d = ERR_OVER;
        else if (op_rd && empty) err_d = ERR_UNDER;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            rd_dat_q <= '0;
            rd_vld_q <= 1'b0;
            err_q    <= ERR_NONE;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            rd_dat_q <= rd_dat_d;
            rd_vld_q <= rd_vld_d;
            err_q    <= err_d;
        end
    end

    // Storage is never cleared; occupancy alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (rst_n && push) mem_q[wr_ptr_q] <= xa_data_in;
    end

    assign wa_data     = mem_q[rd_ptr_q];
    assign wa_vld      = ~empty;
    assign xa_af       = (cnt_q >= CW'(AF_LEVEL));
    assign fifo_cnt    = cnt_q;
    assign xa_data_out = rd_dat_q;
    assign xa_rd_vld   = rd_vld_q;
    assign xa_err      = err_q;
endmodule
